matmul_job_controller: RTL and testbench

Sequencing controller for the systolic matrix multiplier. It accepts one N×N matrix-multiply job at a time over a valid/ready handshake and latches the A and B operands. It clears the array and holds the operands stable while the systolic schedule runs, then captures the C result bus and presents it on a valid/ready result port. It sits between the host/DMA job queue and the multiplier instance.

---
 rtl/matmul_job_controller.sv | 126 ++++++++++++
 tb/tb_matmul_job_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_controller.sv
// Job sequencer for the N x N systolic multiplier: accept, clear, run, capture, present.
// Defining MATMUL_CTRL_PERF_EN adds the jobs_done / busy_cycles counters.
module matmul_job_controller #(
    parameter int N         = 2,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [N*N*OP_WIDTH-1:0]       job_a,
    input  logic [N*N*OP_WIDTH-1:0]       job_b,
    input  logic                          abort,
    output logic                          arr_reset,
    output logic [N*N*OP_WIDTH-1:0]       arr_a,
    output logic [N*N*OP_WIDTH-1:0]       arr_b,
    input  logic [N*N*ACC_WIDTH-1:0]      arr_c,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [N*N*ACC_WIDTH-1:0]      res_c
`ifdef MATMUL_CTRL_PERF_EN
    ,
    output logic [31:0]                   jobs_done,
    output logic [31:0]                   busy_cycles
`endif
);

    localparam int         RUN_CYCLES = 3*N + 1;
    localparam logic [7:0] LAST_CNT   = 8'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESULT} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [7:0]                 r_cnt;
    logic                       r_abort_flush;
    logic [N*N*OP_WIDTH-1:0]    r_a;
    logic [N*N*OP_WIDTH-1:0]    r_b;
    logic [N*N*ACC_WIDTH-1:0]   r_c;
    logic                       w_clear;
    logic                       w_accept;
    logic                       w_abort_run;
    logic                       w_capture;
    logic                       w_res_hs;

    assign w_accept    = job_valid && job_ready;
    assign w_abort_run = abort && (r_state == S_CLEAR || r_state == S_RUN);
    assign w_capture   = (r_state == S_RUN) && (r_cnt == LAST_CNT) && !abort;
    assign w_res_hs    = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (job_valid) w_next = S_CLEAR;
            S_CLEAR:  w_next = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)                 w_next = S_IDLE;
                else if (r_cnt == LAST_CNT) w_next = S_RESULT;
            end
            S_RESULT: if (res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        job_ready = 1'b0;
        res_valid = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_IDLE:   job_ready = 1'b1;
            S_CLEAR:  w_clear   = 1'b1;
            S_RESULT: res_valid = 1'b1;
            default:  ;
        endcase
    end

    // An aborted job leaves partial sums in the array, so flush it once more from IDLE.
    assign arr_reset = reset | w_clear | r_abort_flush;
    assign arr_a     = r_a;
    assign arr_b     = r_b;
    assign res_c     = r_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_abort_flush <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
        end else begin
            r_abort_flush <= w_abort_run;
            if (r_state == S_RUN) r_cnt <= r_cnt + 8'd1;
            else                  r_cnt <= '0;
            if (w_accept) begin
                r_a <= job_a;
                r_b <= job_b;
            end
            if (w_capture) r_c <= arr_c;
        end
    end

`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] r_jobs_done;
    logic [31:0] r_busy_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_jobs_done   <= '0;
            r_busy_cycles <= '0;
        end else begin
            if (w_res_hs)          r_jobs_done   <= r_jobs_done + 32'd1;
            if (r_state != S_IDLE) r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign jobs_done   = r_jobs_done;
    assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_matmul_job_controller.sv
// Bench for matmul_job_controller: a behavioural multiplier stand-in plus a plain-arithmetic matmul reference.
module tb_matmul_job_controller;
    localparam int N      = 2;
    localparam int OPW    = 8;
    localparam int ACCW   = 32;
    localparam int AW     = N*N*OPW;
    localparam int CW     = N*N*ACCW;
    localparam int RUNC   = 3*N + 1;
    localparam int LAT    = 3*N + 2;
    localparam int PERIOD = 3*N + 4;

    logic          clk = 1'b0;
    logic          reset, job_valid, job_ready, abort, arr_reset, res_valid, res_ready;
    logic [AW-1:0] job_a, job_b, arr_a, arr_b;
    logic [CW-1:0] arr_c, res_c;
    logic [CW-1:0] last_exp;
`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0]   jobs_done, busy_cycles;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_job_controller #(.N(N), .OP_WIDTH(OPW), .ACC_WIDTH(ACCW)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .abort(abort), .arr_reset(arr_reset),
        .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c), .res_valid(res_valid),
        .res_ready(res_ready), .res_c(res_c)
`ifdef MATMUL_CTRL_PERF_EN
        , .jobs_done(jobs_done), .busy_cycles(busy_cycles)
`endif
    );

    // Multiplier stand-in: cleared by arr_reset, then adds one outer-product term per cycle and holds.
    logic [ACCW-1:0] m_acc [N*N];
    int              m_step;
    always @(posedge clk) begin
        if (arr_reset) begin
            for (int i = 0; i < N*N; i++) m_acc[i] <= '0;
            m_step <= 0;
        end else if (m_step < N) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    m_acc[r*N+c] <= m_acc[r*N+c] + ACCW'(arr_a[(r*N+m_step)*OPW +: OPW]) * ACCW'(arr_b[(m_step*N+c)*OPW +: OPW]);
            m_step <= m_step + 1;
        end
    end
    always_comb begin
        arr_c = '0;
        for (int i = 0; i < N*N; i++) arr_c[i*ACCW +: ACCW] = m_acc[i];
    end

    function automatic logic [CW-1:0] ref_mul(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [CW-1:0] c;
        int unsigned   s, x, y;
        c = '0;
        for (int r = 0; r < N; r++)
            for (int col = 0; col < N; col++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    x = a[(r*N+k)*OPW +: OPW];
                    y = b[(k*N+col)*OPW +: OPW];
                    s = s + x*y;
                end
                c[(r*N+col)*ACCW +: ACCW] = s;
            end
        return c;
    endfunction

    function automatic logic [AW-1:0] rand_mat();
        logic [AW-1:0] m;
        for (int i = 0; i < N*N; i++) m[i*OPW +: OPW] = OPW'($urandom_range(1, 255));
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job for one edge (caller guarantees IDLE); returns after the accepting edge.
    task automatic offer(input logic [AW-1:0] a, input logic [AW-1:0] b);
        job_a = a; job_b = b; job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 60) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0; job_a = '0; job_b = '0;
        tick(); tick();
        total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL rst_job_ready got=%b exp=1", job_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        total++; if (arr_reset !== 1'b1) begin bad++; $display("FAIL rst_arr_reset got=%b exp=1", arr_reset); end
        total++; if (arr_a !== '0 || arr_b !== '0 || res_c !== '0) begin bad++; $display("FAIL rst_data got a=%0h b=%0h c=%0h exp=0", arr_a, arr_b, res_c); end
        reset = 1'b0;
        tick();
        total++; if (job_ready !== 1'b1 || arr_reset !== 1'b0) begin bad++; $display("FAIL rst_release got rdy=%b arst=%b exp rdy=1 arst=0", job_ready, arr_reset); end
`ifdef MATMUL_CTRL_PERF_EN
        total++; if (jobs_done !== 32'd0 || busy_cycles !== 32'd0) begin bad++; $display("FAIL rst_perf got done=%0d busy=%0d exp=0", jobs_done, busy_cycles); end
`endif
    endtask

    task automatic test_basic();
        logic [AW-1:0] a, b;
        logic [CW-1:0] exp_c;
        int lat, rcnt;
        a = {8'd4, 8'd3, 8'd2, 8'd1};
        b = {8'd8, 8'd7, 8'd6, 8'd5};
        exp_c = {32'd50, 32'd43, 32'd22, 32'd19};
        res_ready = 1'b1;
        offer(a, b);
        total++; if (job_ready !== 1'b0 || arr_reset !== 1'b1) begin bad++; $display("FAIL basic_accept got rdy=%b arst=%b exp rdy=0 arst=1", job_ready, arr_reset); end
        total++; if (arr_a !== a || arr_b !== b) begin bad++; $display("FAIL basic_operands got a=%0h b=%0h exp a=%0h b=%0h", arr_a, arr_b, a, b); end
        rcnt = 1; lat = 0;
        while (!res_valid && lat < 60) begin tick(); lat++; if (arr_reset) rcnt++; end
        total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        total++; if (rcnt !== 1) begin bad++; $display("FAIL basic_clear_pulse got=%0d exp=1", rcnt); end
        total++; if (res_c !== exp_c) begin bad++; $display("FAIL basic_result got=%0h exp=%0h", res_c, exp_c); end
        last_exp = exp_c;
        tick();
        total++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin bad++; $display("FAIL basic_handshake got vld=%b rdy=%b exp vld=0 rdy=1", res_valid, job_ready); end
`ifdef MATMUL_CTRL_PERF_EN
        total++; if (jobs_done !== 32'd1 || busy_cycles !== 32'd9) begin bad++; $display("FAIL basic_perf got done=%0d busy=%0d exp done=1 busy=9", jobs_done, busy_cycles); end
`endif
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a, b, a2, b2;
        logic [CW-1:0] exp_c;
        int lat;
        a = rand_mat(); b = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
        exp_c = ref_mul(a, b);
        res_ready = 1'b0;
        offer(a, b);
        wait_result(lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        job_a = a2; job_b = b2; job_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || job_ready !== 1'b0 || res_c !== exp_c) begin
                bad++; $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b c=%0h exp vld=1 rdy=0 c=%0h", i, res_valid, job_ready, res_c, exp_c);
            end
        end
        res_ready = 1'b1;
        tick();
        total++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin bad++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", res_valid, job_ready); end
        tick();
        job_valid = 1'b0;
        total++; if (job_ready !== 1'b0 || arr_reset !== 1'b1 || arr_a !== a2) begin bad++; $display("FAIL bp_next_accept got rdy=%b arst=%b a=%0h exp rdy=0 arst=1 a=%0h", job_ready, arr_reset, arr_a, a2); end
        wait_result(lat);
        exp_c = ref_mul(a2, b2);
        total++; if (res_c !== exp_c || lat !== LAT) begin bad++; $display("FAIL bp_second got c=%0h lat=%0d exp c=%0h lat=%0d", res_c, lat, exp_c, LAT); end
        last_exp = exp_c;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a1, b1, a2, b2;
        logic          got1;
        int            t, acc2, lat;
        a1 = rand_mat(); b1 = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
        res_ready = 1'b1;
        job_a = a1; job_b = b1; job_valid = 1'b1;
        tick();
        job_a = a2; job_b = b2;
        got1 = 1'b0; acc2 = -1; t = 0;
        while (acc2 < 0 && t < 40) begin
            tick(); t++;
            if (res_valid && !got1) begin
                got1 = 1'b1;
                total++; if (res_c !== ref_mul(a1, b1)) begin bad++; $display("FAIL b2b_first got=%0h exp=%0h", res_c, ref_mul(a1, b1)); end
            end
            if (got1 && !job_ready && arr_reset) acc2 = t;
        end
        job_valid = 1'b0;
        total++; if (acc2 !== PERIOD) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc2, PERIOD); end
        wait_result(lat);
        total++; if (res_c !== ref_mul(a2, b2) || lat !== LAT) begin bad++; $display("FAIL b2b_second got c=%0h lat=%0d exp c=%0h lat=%0d", res_c, lat, ref_mul(a2, b2), LAT); end
        last_exp = ref_mul(a2, b2);
        tick();
    endtask

    task automatic test_abort();
        logic [AW-1:0] a, b;
        logic          seen;
        int            lat;
        res_ready = 1'b1;
        offer(rand_mat(), rand_mat());
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (job_ready !== 1'b1 || arr_reset !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL abort_idle got rdy=%b arst=%b vld=%b exp 1 1 0", job_ready, arr_reset, res_valid); end
        tick();
        total++; if (arr_reset !== 1'b0) begin bad++; $display("FAIL abort_flush_len got=%b exp=0", arr_reset); end
        seen = 1'b0;
        repeat (15) begin if (res_valid) seen = 1'b1; tick(); end
        total++; if (seen !== 1'b0 || res_c !== last_exp) begin bad++; $display("FAIL abort_no_result got seen=%b c=%0h exp seen=0 c=%0h", seen, res_c, last_exp); end
        a = rand_mat(); b = rand_mat();
        offer(a, b);
        wait_result(lat);
        total++; if (res_c !== ref_mul(a, b) || lat !== LAT) begin bad++; $display("FAIL abort_followup got c=%0h lat=%0d exp c=%0h lat=%0d", res_c, lat, ref_mul(a, b), LAT); end
        last_exp = ref_mul(a, b);
        tick();
    endtask

    task automatic test_abort_final();
        logic seen;
        res_ready = 1'b1;
        offer(rand_mat(), rand_mat());
        repeat (RUNC) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (res_valid !== 1'b0 || job_ready !== 1'b1 || arr_reset !== 1'b1) begin bad++; $display("FAIL abortfin_idle got vld=%b rdy=%b arst=%b exp 0 1 1", res_valid, job_ready, arr_reset); end
        seen = 1'b0;
        repeat (12) begin if (res_valid) seen = 1'b1; tick(); end
        total++; if (seen !== 1'b0 || res_c !== last_exp) begin bad++; $display("FAIL abortfin_res got seen=%b c=%0h exp seen=0 c=%0h", seen, res_c, last_exp); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a, b;
        logic [CW-1:0] exp_c;
        logic          seen;
        int            p, d, lat;
        for (int it = 0; it < 10; it++) begin
            a = rand_mat(); b = rand_mat();
            res_ready = 1'b0;
            offer(a, b);
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, RUNC);
                repeat (p) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                seen = 1'b0;
                repeat (12) begin if (res_valid) seen = 1'b1; tick(); end
                total++; if (seen !== 1'b0 || res_c !== last_exp) begin bad++; $display("FAIL rand_abort it=%0d p=%0d got seen=%b c=%0h exp seen=0 c=%0h", it, p, seen, res_c, last_exp); end
            end else begin
                exp_c = ref_mul(a, b);
                wait_result(lat);
                total++; if (res_c !== exp_c || lat !== LAT) begin bad++; $display("FAIL rand_result it=%0d got c=%0h lat=%0d exp c=%0h lat=%0d", it, res_c, lat, exp_c, LAT); end
                last_exp = exp_c;
                d = $urandom_range(0, 4);
                repeat (d) tick();
                res_ready = 1'b1;
                tick();
                res_ready = 1'b0;
                total++; if (res_valid !== 1'b0 || job_ready !== 1'b1 || res_c !== exp_c) begin bad++; $display("FAIL rand_drain it=%0d got vld=%b rdy=%b c=%0h exp 0 1 %0h", it, res_valid, job_ready, res_c, exp_c); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        res_ready = 1'b0;
        offer(rand_mat(), rand_mat());
        repeat (4) tick();
        reset = 1'b1;
        tick();
        total++; if (job_ready !== 1'b1 || res_valid !== 1'b0 || arr_reset !== 1'b1) begin bad++; $display("FAIL rstrun_ctrl got rdy=%b vld=%b arst=%b exp 1 0 1", job_ready, res_valid, arr_reset); end
        total++; if (arr_a !== '0 || arr_b !== '0 || res_c !== '0) begin bad++; $display("FAIL rstrun_data got a=%0h b=%0h c=%0h exp=0", arr_a, arr_b, res_c); end
        reset = 1'b0;
        tick();
        total++; if (job_ready !== 1'b1 || arr_reset !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL rstrun_release got rdy=%b arst=%b vld=%b exp 1 0 0", job_ready, arr_reset, res_valid); end
        offer(rand_mat(), rand_mat());
        wait_result(lat);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL rstres_reach got vld=%b exp=1", res_valid); end
        reset = 1'b1;
        tick();
        total++; if (res_valid !== 1'b0 || res_c !== '0 || arr_a !== '0 || job_ready !== 1'b1) begin bad++; $display("FAIL rstres_out got vld=%b c=%0h a=%0h rdy=%b exp 0 0 0 1", res_valid, res_c, arr_a, job_ready); end
        reset = 1'b0;
        tick();
        total++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL rstres_release got rdy=%b vld=%b exp 1 0", job_ready, res_valid); end
`ifdef MATMUL_CTRL_PERF_EN
        total++; if (jobs_done !== 32'd0) begin bad++; $display("FAIL rstres_perf got=%0d exp=0", jobs_done); end
`endif
    endtask

    initial begin
        reset = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
        job_a = '0; job_b = '0; last_exp = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_abort_final();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
